// File: rtl/serial_chunk_adder_pkg.sv
// Shared state type and sizing helpers for the chunk-serial add/subtract unit.
// Defaults give a 16-bit datapath processed 4 bits per cycle.
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHUNK    = 4;
    localparam int DEF_N_CHUNKS = DEF_WIDTH / DEF_CHUNK;

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n_chunks);
        return (n_chunks > 1) ? $clog2(n_chunks) : 1;
    endfunction

endpackage

// File: rtl/serial_chunk_adder_ripple.sv
// Purely combinational CHUNK-bit ripple chain built from 1-bit full-adder cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_ripple_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_co    = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per cycle with a
// registered carry between chunks, valid/ready on both sides, all outputs registered.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cn,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co,
    output logic             o_ov
);

    localparam int N_CHUNKS = WIDTH / CHUNK;
    localparam int CNT_W    = cnt_width(N_CHUNKS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("serial_chunk_adder: WIDTH must be an exact multiple of CHUNK");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_work;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_s;
    logic               r_co;
    logic               r_ov;

    logic [CHUNK-1:0]   w_chunk_a;
    logic [CHUNK-1:0]   w_chunk_b;
    logic [CHUNK-1:0]   w_chunk_s;
    logic               w_chunk_co;
    logic               w_chunk_c_msb;
    logic [WIDTH-1:0]   w_result;
    logic               w_accept;
    logic               w_last;
    logic               w_in_ready_d;
    logic               w_out_valid_d;

    assign w_accept  = (r_state == IDLE) && r_in_ready && i_in_valid;
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_chunk_a = r_op_a[int'(r_cnt) * CHUNK +: CHUNK];
    assign w_chunk_b = r_op_b[int'(r_cnt) * CHUNK +: CHUNK];

    chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .i_a     (w_chunk_a),
        .i_b     (w_chunk_b),
        .i_ci    (r_carry),
        .o_s     (w_chunk_s),
        .o_co    (w_chunk_co),
        .o_c_msb (w_chunk_c_msb)
    );

    // Working result with the current chunk merged in; on the last chunk this is the final S.
    always_comb begin
        w_result = r_work;
        w_result[int'(r_cnt) * CHUNK +: CHUNK] = w_chunk_s;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_next_state = RUN;
            RUN:     if (w_last)      w_next_state = DONE;
            DONE:    if (i_out_ready) w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so they can be registered.
    always_comb begin
        w_in_ready_d  = (w_next_state == IDLE);
        w_out_valid_d = (w_next_state == DONE);
    end

    // Subtraction is folded in at capture: A + ~B + 1 - Cn, i.e. carry-in = Cn ^ Sub.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_op_a  <= i_a;
            r_op_b  <= i_sub ? ~i_b : i_b;
            r_carry <= i_cn ^ i_sub;
            r_cnt   <= '0;
            r_work  <= '0;
        end else if (r_state == RUN) begin
            r_work  <= w_result;
            r_carry <= w_chunk_co;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_co        <= 1'b0;
            r_ov        <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_d;
            r_out_valid <= w_out_valid_d;
            if ((r_state == RUN) && w_last) begin
                r_s  <= w_result;
                r_co <= w_chunk_co;
                r_ov <= w_chunk_co ^ w_chunk_c_msb;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_s         = r_s;
    assign o_co        = r_co;
    assign o_ov        = r_ov;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench: a CHUNK=4 instance for directed handshake/reset scenarios plus
// three free-running random lanes at CHUNK 1, 4 and 16 checked against an arithmetic model.
module tb_serial_chunk_adder;

    localparam int W        = 16;
    localparam int N_DIR    = 4;
    localparam int LANE_OPS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    logic          rstN;
    logic          laneRstN;
    logic          dInValid, dInReady, dCn, dSub, dOutValid, dOutReady, dCo, dOv;
    logic [W-1:0]  dA, dB, dS;
    logic [W+1:0]  dirQ[$];

    serial_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_in_valid  (dInValid),
        .o_in_ready  (dInReady),
        .i_a         (dA),
        .i_b         (dB),
        .i_cn        (dCn),
        .i_sub       (dSub),
        .o_out_valid (dOutValid),
        .i_out_ready (dOutReady),
        .o_s         (dS),
        .o_co        (dCo),
        .o_ov        (dOv)
    );

    // Reference: {Co,S} = A + B' + cin over WIDTH+1 bits; Ov = carry into MSB ^ carry out.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cn, input logic sub);
        logic [W-1:0] bx;
        logic         cin;
        int unsigned  full;
        int unsigned  low;
        logic         co;
        bx   = sub ? ~b : b;
        cin  = cn ^ sub;
        full = 32'(a) + 32'(bx) + 32'(cin);
        low  = 32'(a[W-2:0]) + 32'(bx[W-2:0]) + 32'(cin);
        co   = full[W];
        return {co ^ low[W-1], co, full[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        nTests++;
        nFail++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Caller is positioned at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cn, input logic sub, output int waited);
        dA = a; dB = b; dCn = cn; dSub = sub; dInValid = 1'b1;
        waited = 0;
        while (!dInReady && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) reportTimeout("directed accept");
        else dirQ.push_back(refModel(a, b, cn, sub));
        @(negedge clk);
        dInValid = 1'b0;
        dA = W'($urandom);
        dB = W'($urandom);
    endtask

    task automatic waitLatency(output int lat);
        lat = 0;
        while (!dOutValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cn, input logic sub);
        int waited;
        int lat;
        applyStimulus(a, b, cn, sub, waited);
        waitLatency(lat);
        checkOutput({name, " latency"}, lat, N_DIR);
        @(negedge clk);
        checkOutput({name, " back to idle {valid,ready}"}, {dOutValid, dInReady}, 2'b01);
    endtask

    // Directed monitor: compares whenever a result handshake is about to happen.
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (dOutValid && dOutReady) begin
                if (dirQ.size() == 0) begin
                    checkOutput("directed unexpected result", 32'(dOutValid), 0);
                end else begin
                    e = dirQ.pop_front();
                    checkOutput("directed S", dS, e[W-1:0]);
                    checkOutput("directed Co", dCo, e[W]);
                    checkOutput("directed Ov", dOv, e[W+1]);
                end
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        localparam int CH = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
        logic          inValid, inReady, cn, sub, outValid, outReady, co, ov;
        logic [W-1:0]  a, b, s;
        logic [W+1:0]  q[$];
        logic          laneDone = 1'b0;

        serial_chunk_adder #(.WIDTH(W), .CHUNK(CH)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (laneRstN),
            .i_in_valid  (inValid),
            .o_in_ready  (inReady),
            .i_a         (a),
            .i_b         (b),
            .i_cn        (cn),
            .i_sub       (sub),
            .o_out_valid (outValid),
            .i_out_ready (outReady),
            .o_s         (s),
            .o_co        (co),
            .o_ov        (ov)
        );

        initial begin
            int guard;
            inValid = 1'b0; a = '0; b = '0; cn = 1'b0; sub = 1'b0;
            @(posedge laneRstN);
            for (int k = 0; k < LANE_OPS; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                a = pickOperand(); b = pickOperand();
                cn = 1'($urandom); sub = 1'($urandom);
                inValid = 1'b1;
                guard = 0;
                while (!inReady && guard < 200) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 200) begin
                    reportTimeout($sformatf("lane CH=%0d accept", CH));
                    break;
                end
                q.push_back(refModel(a, b, cn, sub));
                @(negedge clk);
                inValid = 1'b0;
                a = W'($urandom); b = W'($urandom);
            end
        end

        initial begin
            int popped;
            logic [W+1:0] e;
            outReady = 1'b0;
            popped = 0;
            @(posedge laneRstN);
            while (popped < LANE_OPS) begin
                @(negedge clk);
                outReady = ($urandom_range(0, 3) != 0);
                if (outValid && outReady) begin
                    if (q.size() == 0) begin
                        checkOutput($sformatf("lane CH=%0d unexpected result", CH), 32'(outValid), 0);
                    end else begin
                        e = q.pop_front();
                        checkOutput($sformatf("lane CH=%0d S", CH), s, e[W-1:0]);
                        checkOutput($sformatf("lane CH=%0d Co", CH), co, e[W]);
                        checkOutput($sformatf("lane CH=%0d Ov", CH), ov, e[W+1]);
                    end
                    popped++;
                end
            end
            laneDone = 1'b1;
        end
    end

    initial begin
        int waited;
        int lat;
        int guard;
        logic [W+1:0] e;
        rstN = 1'b0; laneRstN = 1'b0;
        dInValid = 1'b0; dA = '0; dB = '0; dCn = 1'b0; dSub = 1'b0; dOutReady = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset {in_ready,out_valid}", {dInReady, dOutValid}, 2'b10);
        checkOutput("reset {S,Co,Ov}", {dS, dCo, dOv}, '0);
        rstN = 1'b1; laneRstN = 1'b1;
        @(negedge clk);
        dOutReady = 1'b1;

        runOp("add basic", 16'h1234, 16'h0FCD, 1'b0, 1'b0);
        runOp("add carry out", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        runOp("add overflow", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        runOp("sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
        runOp("sub borrow-in", 16'h0007, 16'h0005, 1'b1, 1'b1);

        // Backpressure: result must hold while out_ready is low and inputs churn.
        dOutReady = 1'b0;
        e = refModel(16'h4321, 16'h1111, 1'b0, 1'b0);
        applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b0, waited);
        waitLatency(lat);
        checkOutput("hold latency", lat, N_DIR);
        for (int i = 0; i < 3; i++) begin
            dInValid = (i % 2 == 0);
            dA = W'($urandom); dB = W'($urandom); dSub = 1'($urandom);
            @(negedge clk);
            checkOutput("hold S", dS, e[W-1:0]);
            checkOutput("hold {Co,Ov}", {dCo, dOv}, {e[W], e[W+1]});
            checkOutput("hold {in_ready,out_valid}", {dInReady, dOutValid}, 2'b01);
        end
        dInValid = 1'b0;
        dOutReady = 1'b1;
        @(negedge clk);
        checkOutput("release {in_ready,out_valid}", {dInReady, dOutValid}, 2'b10);
        checkOutput("S held after release", dS, e[W-1:0]);
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, waited);
        checkOutput("back-to-back accept wait", waited, 0);
        waitLatency(lat);
        checkOutput("back-to-back latency", lat, N_DIR);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN (counter at 2).
        applyStimulus(16'hABCD, 16'h1234, 1'b1, 1'b0, waited);
        repeat (2) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("mid-run reset {in_ready,out_valid}", {dInReady, dOutValid}, 2'b10);
        checkOutput("mid-run reset {S,Co,Ov}", {dS, dCo, dOv}, '0);
        dirQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        runOp("after reset", 16'h8000, 16'h0001, 1'b0, 1'b1);

        guard = 0;
        while (!(g_lane[0].laneDone && g_lane[1].laneDone && g_lane[2].laneDone) && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("random lanes complete",
                    {g_lane[2].laneDone, g_lane[1].laneDone, g_lane[0].laneDone}, 3'b111);
        checkOutput("directed queue drained", dirQ.size(), 0);
        checkOutput("lane queues drained",
                    g_lane[0].q.size() + g_lane[1].q.size() + g_lane[2].q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
